// File: rtl/uart_receiver_fsm.sv
// UART receiver: 16x-oversampled, LSB-first, 1 start bit, DATA_BITS data, STOP_BITS stop, no parity.
// Recovers one word per frame and flags framing errors; a held break reports a single error.
module uart_receiver_fsm #(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 sample_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 busy,
  output logic                 chg_state
);

  localparam int unsigned STOP_TICKS = STOP_BITS * 16;
  localparam int unsigned SW         = $clog2(STOP_TICKS);
  localparam int unsigned NW         = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e                 state_q, state_d;
  logic                   rx_meta_q, rx_s_q;
  logic [DATA_BITS-1:0]   shreg_q, shreg_d;
  logic [SW-1:0]          s_cnt_q, s_cnt_d;
  logic [NW-1:0]          n_cnt_q, n_cnt_d;
  logic                   armed_q, armed_d;
  logic                   err_q, err_d;
  logic [DATA_BITS-1:0]   rx_data_q, rx_data_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   frame_err_q, frame_err_d;
  logic                   chg_state_q;
  logic                   err_now;

  always_ff @(posedge clock) begin
    if (reset) begin
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      state_q     <= StIdle;
      shreg_q     <= '0;
      s_cnt_q     <= '0;
      n_cnt_q     <= '0;
      armed_q     <= 1'b1;
      err_q       <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      chg_state_q <= 1'b0;
    end else begin
      rx_meta_q   <= rx;
      rx_s_q      <= rx_meta_q;
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      s_cnt_q     <= s_cnt_d;
      n_cnt_q     <= n_cnt_d;
      armed_q     <= armed_d;
      err_q       <= err_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      chg_state_q <= (state_d != state_q);
    end
  end

  // The final stop sample is folded in before deciding the frame outcome.
  assign err_now = err_q | ((s_cnt_q[3:0] == 4'hF) & ~rx_s_q);

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    s_cnt_d     = s_cnt_q;
    n_cnt_d     = n_cnt_q;
    armed_d     = armed_q;
    err_d       = err_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    if (sample_tick) begin
      unique case (state_q)
        StIdle: begin
          if (rx_s_q) begin
            armed_d = 1'b1;
          end else if (armed_q) begin
            s_cnt_d = '0;
            state_d = StStart;
          end
        end
        StStart: begin
          if (s_cnt_q == SW'(7)) begin
            if (!rx_s_q) begin
              s_cnt_d = '0;
              n_cnt_d = '0;
              state_d = StData;
            end else begin
              state_d = StIdle;
            end
          end else begin
            s_cnt_d = s_cnt_q + SW'(1);
          end
        end
        StData: begin
          if (s_cnt_q == SW'(15)) begin
            shreg_d = {rx_s_q, shreg_q[DATA_BITS-1:1]};
            s_cnt_d = '0;
            if (n_cnt_q == NW'(DATA_BITS - 1)) begin
              err_d   = 1'b0;
              state_d = StStop;
            end else begin
              n_cnt_d = n_cnt_q + NW'(1);
            end
          end else begin
            s_cnt_d = s_cnt_q + SW'(1);
          end
        end
        StStop: begin
          if (s_cnt_q == SW'(STOP_TICKS - 1)) begin
            state_d = StIdle;
            if (err_now) begin
              frame_err_d = 1'b1;
              armed_d     = 1'b0;
            end else begin
              rx_data_d  = shreg_q;
              rx_valid_d = 1'b1;
            end
          end else begin
            err_d   = err_now;
            s_cnt_d = s_cnt_q + SW'(1);
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign chg_state = chg_state_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_uart_receiver_fsm.sv
// Scoreboard bench for uart_receiver_fsm: one 1-stop-bit and one 2-stop-bit instance,
// expected words/errors are queued as frames are driven and popped when the DUT reports.
module tb_uart_receiver_fsm;

  typedef struct packed {
    logic       err;
    logic [7:0] data;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b0;
  logic       rx0 = 1'b1;
  logic       rx1 = 1'b1;
  logic [7:0] data0, data1;
  logic       valid0, valid1, ferr0, ferr1, busy0, busy1, chg0, chg1;

  int         total = 0;
  int         bad = 0;
  int         tcnt = 0;
  int         chg_cnt = 0;
  logic [7:0] last_good [2];
  exp_t       q0[$];
  exp_t       q1[$];

  uart_receiver_fsm #(.DATA_BITS(8), .STOP_BITS(1)) dut0 (
    .clock(clk), .reset(reset), .sample_tick(tick), .rx(rx0), .rx_data(data0),
    .rx_valid(valid0), .frame_err(ferr0), .busy(busy0), .chg_state(chg0)
  );

  uart_receiver_fsm #(.DATA_BITS(8), .STOP_BITS(2)) dut1 (
    .clock(clk), .reset(reset), .sample_tick(tick), .rx(rx1), .rx_data(data1),
    .rx_valid(valid1), .frame_err(ferr1), .busy(busy1), .chg_state(chg1)
  );

  always #5 clk = ~clk;

  // One tick every 4 clocks, updated away from the active edge.
  always @(negedge clk) begin
    tcnt = tcnt + 1;
    tick = (tcnt % 4 == 0);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic observe(input int idx, input logic v, input logic fe, input logic [7:0] d,
                         input logic b);
    exp_t e;
    int   sz;
    sz = (idx == 0) ? q0.size() : q1.size();
    if (v || fe) begin
      check($sformatf("excl%0d", idx), {31'd0, v & fe}, 0);
      if (sz == 0) begin
        check($sformatf("spurious%0d", idx), {30'd0, v, fe}, 0);
      end else begin
        e = (idx == 0) ? q0.pop_front() : q1.pop_front();
        check($sformatf("kind%0d", idx), {31'd0, fe}, {31'd0, e.err});
        check($sformatf("data%0d", idx), {24'd0, d}, {24'd0, e.data});
        check($sformatf("busy_at_out%0d", idx), {31'd0, b}, 0);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      observe(0, valid0, ferr0, data0, busy0);
      observe(1, valid1, ferr1, data1, busy1);
      if (chg0) chg_cnt++;
    end
  end

  task automatic push_exp(input int idx, input logic err, input logic [7:0] d);
    exp_t e;
    e.err = err;
    if (err) begin
      e.data = last_good[idx];
    end else begin
      e.data = d;
      last_good[idx] = d;
    end
    if (idx == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  task automatic drive_bit(input int idx, input logic v, input int ticks);
    if (idx == 0) rx0 = v;
    else rx1 = v;
    repeat (ticks * 4) @(negedge clk);
  endtask

  task automatic send_frame(input int idx, input logic [7:0] d, input int nstop,
                            input logic s0, input logic s1, input int last_ticks);
    drive_bit(idx, 1'b0, 16);
    for (int i = 0; i < 8; i++) drive_bit(idx, d[i], 16);
    for (int i = 0; i < nstop; i++)
      drive_bit(idx, (i == 0) ? s0 : s1, (i == nstop - 1) ? last_ticks : 16);
  endtask

  task automatic wait_drain(input int idx);
    int n;
    int sz;
    n = 0;
    sz = (idx == 0) ? q0.size() : q1.size();
    while (sz != 0 && n < 4000) begin
      @(negedge clk);
      n++;
      sz = (idx == 0) ? q0.size() : q1.size();
    end
    check($sformatf("drain%0d", idx), sz, 0);
  endtask

  task automatic check_reset_state();
    check("rst_data", {24'd0, data0}, 0);
    check("rst_valid", {31'd0, valid0}, 0);
    check("rst_ferr", {31'd0, ferr0}, 0);
    check("rst_busy", {31'd0, busy0}, 0);
    check("rst_chg", {31'd0, chg0}, 0);
    check("rst_data2", {24'd0, data1}, 0);
  endtask

  initial begin
    last_good[0] = 8'h00;
    last_good[1] = 8'h00;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_reset_state();

    // Single frame
    push_exp(0, 1'b0, 8'h55);
    send_frame(0, 8'h55, 1, 1'b1, 1'b1, 16);
    drive_bit(0, 1'b1, 8);
    wait_drain(0);
    check("busy_after_55", {31'd0, busy0}, 0);

    // Back-to-back, next start shortly after the stop-bit mid point
    push_exp(0, 1'b0, 8'hA3);
    push_exp(0, 1'b0, 8'h0F);
    send_frame(0, 8'hA3, 1, 1'b1, 1'b1, 11);
    send_frame(0, 8'h0F, 1, 1'b1, 1'b1, 16);
    drive_bit(0, 1'b1, 16);
    wait_drain(0);

    // Start glitch
    chg_cnt = 0;
    drive_bit(0, 1'b0, 4);
    drive_bit(0, 1'b1, 20);
    check("glitch_chg", chg_cnt, 2);
    check("glitch_busy", {31'd0, busy0}, 0);

    // Framing error then a held break, then recovery
    push_exp(0, 1'b1, 8'h00);
    send_frame(0, 8'h81, 1, 1'b0, 1'b0, 16);
    drive_bit(0, 1'b0, 640);
    wait_drain(0);
    check("break_data", {24'd0, data0}, 8'h0F);
    drive_bit(0, 1'b1, 32);
    push_exp(0, 1'b0, 8'h5A);
    send_frame(0, 8'h5A, 1, 1'b1, 1'b1, 16);
    drive_bit(0, 1'b1, 8);
    wait_drain(0);

    // Two stop bits: second one low, then a clean frame
    push_exp(1, 1'b1, 8'h00);
    send_frame(1, 8'h96, 2, 1'b1, 1'b0, 16);
    drive_bit(1, 1'b1, 32);
    wait_drain(1);
    push_exp(1, 1'b0, 8'h96);
    send_frame(1, 8'h96, 2, 1'b1, 1'b1, 16);
    drive_bit(1, 1'b1, 16);
    wait_drain(1);

    // Reset during data bit 4 of 0xFF
    drive_bit(0, 1'b0, 16);
    drive_bit(0, 1'b1, 72);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    last_good[0] = 8'h00;
    last_good[1] = 8'h00;
    @(negedge clk);
    check_reset_state();
    drive_bit(0, 1'b1, 80);
    check("post_rst_quiet", {31'd0, busy0}, 0);
    push_exp(0, 1'b0, 8'h3C);
    send_frame(0, 8'h3C, 1, 1'b1, 1'b1, 16);
    drive_bit(0, 1'b1, 16);
    wait_drain(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
